// File: rtl/miriscv_prefetch_unit.sv
// miriscv_prefetch_unit
//   Instruction prefetcher between instruction memory and the decode stage.
//   Keeps up to MAX_OUTSTANDING requests in flight and buffers up to FIFO_DEPTH
//   fetched instructions, each tagged with its PC. Redirects (boot load, kill)
//   flush the buffer; responses to requests issued before a redirect are dropped
//   in order.
//
// Ports
//   clk_i, arstn_i               clock, asynchronous active-low reset
//   boot_addr_i                  PC loaded on boot load
//   instr_rvalid_i/rdata_i       in-order memory responses
//   instr_req_o/addr_o           memory request (accepted in the same cycle)
//   cu_pc_bra_i                  kill redirect target
//   cu_stall_f_i                 decode not accepting
//   cu_kill_f_i                  redirect to cu_pc_bra_i
//   cu_boot_addr_load_en_i       redirect to boot_addr_i (wins over kill)
//   fetched_pc_addr_o            PC of head instruction
//   fetched_pc_next_addr_o       head PC + 4
//   instr_o, fetch_rvalid_o      head instruction and its valid
module miriscv_prefetch_unit #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic [XLEN-1:0] boot_addr_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic [XLEN-1:0] cu_pc_bra_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_kill_f_i,
  input  logic            cu_boot_addr_load_en_i,
  output logic [XLEN-1:0] fetched_pc_addr_o,
  output logic [XLEN-1:0] fetched_pc_next_addr_o,
  output logic [31:0]     instr_o,
  output logic            fetch_rvalid_o
);

  localparam int unsigned ILEN = 32;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {StIdle = 1'b0, StRun = 1'b1} state_e;

  state_e          r_state;
  logic [XLEN-1:0] r_req_pc;       // address of next request
  logic [XLEN-1:0] r_rsp_pc;       // PC of next response that will be kept
  logic [OutW-1:0] r_outstanding;  // issued, not yet answered (stale ones included)
  logic [OutW-1:0] r_discard;      // leading responses still to be dropped
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [ILEN-1:0] r_data [FIFO_DEPTH];
  logic [XLEN-1:0] r_pc   [FIFO_DEPTH];

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;

  assign w_redirect = cu_boot_addr_load_en_i | cu_kill_f_i;
  assign w_target   = cu_boot_addr_load_en_i ? boot_addr_i : cu_pc_bra_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp = instr_rvalid_i && (r_outstanding != '0);

  // Credit rule: in-flight requests plus buffered entries never exceed the
  // buffer, so every kept response has a free slot.
  assign w_issue = (r_state == StRun) && !w_redirect
                && (32'(r_outstanding) < MAX_OUTSTANDING)
                && ((32'(r_outstanding) + 32'(r_count)) < FIFO_DEPTH);

  // Responses are never buffered in a redirect cycle; they are stale by then.
  assign w_push = w_rsp && (r_discard == '0) && !w_redirect;
  assign w_pop  = fetch_rvalid_o && !cu_stall_f_i;

  assign instr_req_o            = w_issue;
  assign instr_addr_o           = r_req_pc;
  assign fetch_rvalid_o         = (r_count != '0) && !w_redirect;
  assign instr_o                = r_data[r_rd_ptr];
  assign fetched_pc_addr_o      = r_pc[r_rd_ptr];
  assign fetched_pc_next_addr_o = r_pc[r_rd_ptr] + XLEN'(4);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state       <= StIdle;
      r_req_pc      <= '0;
      r_rsp_pc      <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      if (r_state == StIdle && cu_boot_addr_load_en_i) begin
        r_state <= StRun;
      end

      // No issue happens in a redirect cycle, so this covers both cases.
      if (w_issue && !w_rsp) begin
        r_outstanding <= r_outstanding + OutW'(1);
      end else if (!w_issue && w_rsp) begin
        r_outstanding <= r_outstanding - OutW'(1);
      end

      if (w_redirect) begin
        r_req_pc  <= w_target;
        r_rsp_pc  <= w_target;
        r_count   <= '0;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_discard <= r_outstanding - OutW'(w_rsp);
      end else begin
        if (w_rsp && r_discard != '0) begin
          r_discard <= r_discard - OutW'(1);
        end
        if (w_issue) begin
          r_req_pc <= r_req_pc + XLEN'(4);
        end
        if (w_push) begin
          r_data[r_wr_ptr] <= instr_rdata_i[ILEN-1:0];
          r_pc[r_wr_ptr]   <= r_rsp_pc;
          r_wr_ptr         <= r_wr_ptr + PtrW'(1);
          r_rsp_pc         <= r_rsp_pc + XLEN'(4);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_miriscv_prefetch_unit.sv
// Self-checking bench for miriscv_prefetch_unit: a queue-based reference model
// checked every cycle, a variable-latency memory answering the DUT's requests,
// and directed scenarios with hand-computed literal expectations.
module tb_miriscv_prefetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic            clk_i = 1'b0;
  logic            arstn_i = 1'b0;
  logic [XLEN-1:0] boot_addr_i = '0;
  logic            instr_rvalid_i = 1'b0;
  logic [XLEN-1:0] instr_rdata_i = '0;
  logic            instr_req_o;
  logic [XLEN-1:0] instr_addr_o;
  logic [XLEN-1:0] cu_pc_bra_i = '0;
  logic            cu_stall_f_i = 1'b0;
  logic            cu_kill_f_i = 1'b0;
  logic            cu_boot_addr_load_en_i = 1'b0;
  logic [XLEN-1:0] fetched_pc_addr_o;
  logic [XLEN-1:0] fetched_pc_next_addr_o;
  logic [31:0]     instr_o;
  logic            fetch_rvalid_o;

  miriscv_prefetch_unit #(
    .XLEN            (XLEN),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i                  (clk_i),
    .arstn_i                (arstn_i),
    .boot_addr_i            (boot_addr_i),
    .instr_rvalid_i         (instr_rvalid_i),
    .instr_rdata_i          (instr_rdata_i),
    .instr_req_o            (instr_req_o),
    .instr_addr_o           (instr_addr_o),
    .cu_pc_bra_i            (cu_pc_bra_i),
    .cu_stall_f_i           (cu_stall_f_i),
    .cu_kill_f_i            (cu_kill_f_i),
    .cu_boot_addr_load_en_i (cu_boot_addr_load_en_i),
    .fetched_pc_addr_o      (fetched_pc_addr_o),
    .fetched_pc_next_addr_o (fetched_pc_next_addr_o),
    .instr_o                (instr_o),
    .fetch_rvalid_o         (fetch_rvalid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Memory: answers each DUT request in order, lat cycles later.
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t memq[$];
  int    lat = 1;
  int    cyc = 0;
  bit    orphan_ok = 1'b1;
  int    n_req_seen = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (memq.size() > 0 && memq[0].due == cyc) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_fn(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = $urandom;
      end
    end
  end

  // Reference model: queue of in-flight request PCs (tagged stale on redirect)
  // and queue of buffered PCs; the instruction for a PC is mem_fn(PC).
  typedef struct {logic [31:0] pc; bit stale;} inf_t;
  inf_t        m_inf[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_req_pc;
  bit          m_run;

  initial begin
    bit          redir, exp_req, exp_valid, has_rsp;
    logic [31:0] tgt;
    inf_t        e;
    forever begin
      @(negedge clk_i);
      if (!arstn_i) begin
        m_run = 1'b0;
        m_req_pc = '0;
        m_inf.delete();
        m_fifo.delete();
        chk("rst_req", instr_req_o, 0);
        chk("rst_addr", instr_addr_o, 0);
        chk("rst_valid", fetch_rvalid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", fetched_pc_addr_o, 0);
        chk("rst_pc_next", fetched_pc_next_addr_o, 4);
      end else begin
        redir     = cu_boot_addr_load_en_i || cu_kill_f_i;
        tgt       = cu_boot_addr_load_en_i ? boot_addr_i : cu_pc_bra_i;
        exp_req   = m_run && !redir && (m_inf.size() < MAXO)
                 && (m_inf.size() + m_fifo.size() < DEPTH);
        exp_valid = (m_fifo.size() != 0) && !redir;
        chk("req", instr_req_o, exp_req);
        if (exp_req) chk("addr", instr_addr_o, m_req_pc);
        chk("valid", fetch_rvalid_o, exp_valid);
        if (exp_valid) begin
          chk("head_pc", fetched_pc_addr_o, m_fifo[0]);
          chk("head_pc_next", fetched_pc_next_addr_o, m_fifo[0] + 32'd4);
          chk("head_instr", instr_o, mem_fn(m_fifo[0]));
        end
        if (instr_rvalid_i && m_inf.size() == 0) begin
          n_chk++;
          assert (orphan_ok) else begin
            n_err++;
            $error("FAIL orphan_rsp: response with nothing outstanding (t=%0t)", $time);
          end
        end
        if (instr_req_o) begin
          memq.push_back('{addr: instr_addr_o, due: cyc + lat});
          n_req_seen++;
        end
        has_rsp = 1'b0;
        if (instr_rvalid_i && m_inf.size() > 0) begin
          e = m_inf.pop_front();
          has_rsp = 1'b1;
        end
        if (redir) begin
          foreach (m_inf[i]) m_inf[i].stale = 1'b1;
          m_fifo.delete();
          m_req_pc = tgt;
          if (cu_boot_addr_load_en_i) m_run = 1'b1;
        end else begin
          if (exp_valid && !cu_stall_f_i) void'(m_fifo.pop_front());
          if (has_rsp && !e.stale) m_fifo.push_back(e.pc);
          if (exp_req) begin
            m_inf.push_back('{pc: m_req_pc, stale: 1'b0});
            m_req_pc = m_req_pc + 32'd4;
          end
        end
      end
    end
  end

  // step: enter the next cycle and drive its inputs; peek: sample mid-cycle.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic peek();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset(input bit clear_mem);
    step();
    cu_boot_addr_load_en_i = 1'b0;
    cu_kill_f_i = 1'b0;
    cu_stall_f_i = 1'b0;
    orphan_ok = 1'b1;
    arstn_i = 1'b0;
    if (clear_mem) memq.delete();
    step();
    step();
    arstn_i = 1'b1;
    if (clear_mem) orphan_ok = 1'b0;
  endtask

  // Boot load in cycle T; returns positioned in cycle T+1.
  task automatic boot_at(input logic [31:0] a);
    step();
    boot_addr_i = a;
    cu_boot_addr_load_en_i = 1'b1;
    step();
    cu_boot_addr_load_en_i = 1'b0;
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      peek();
      if (fetch_rvalid_o) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;

    // Boot and stream, 1-cycle memory.
    do_reset(1'b1);
    lat = 1;
    boot_addr_i = 32'h8000_0000;
    step();
    cu_boot_addr_load_en_i = 1'b1;
    peek();
    chk("t1_no_req_in_boot_cycle", instr_req_o, 0);
    step();
    cu_boot_addr_load_en_i = 1'b0;
    peek();
    chk("t1_req_T1", instr_req_o, 1);
    chk("t1_addr_T1", instr_addr_o, 32'h8000_0000);
    step();
    peek();
    chk("t1_addr_T2", instr_addr_o, 32'h8000_0004);
    chk("t1_valid_T2", fetch_rvalid_o, 0);
    step();
    peek();
    chk("t1_valid_T3", fetch_rvalid_o, 1);
    chk("t1_pc_T3", fetched_pc_addr_o, 32'h8000_0000);
    chk("t1_next_T3", fetched_pc_next_addr_o, 32'h8000_0004);
    chk("t1_instr_T3", instr_o, mem_fn(32'h8000_0000));
    step();
    peek();
    chk("t1_valid_T4", fetch_rvalid_o, 1);
    chk("t1_pc_T4", fetched_pc_addr_o, 32'h8000_0004);
    repeat (10) step();

    // Full buffer under stall.
    do_reset(1'b1);
    cu_stall_f_i = 1'b1;
    n_req_seen = 0;
    boot_at(32'h0000_1000);
    repeat (8) step();
    peek();
    chk("t2_req_count", n_req_seen, 4);
    chk("t2_req_blocked", instr_req_o, 0);
    chk("t2_head_valid", fetch_rvalid_o, 1);
    chk("t2_head_pc", fetched_pc_addr_o, 32'h0000_1000);
    step();
    cu_stall_f_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      peek();
      chk("t2_pop_valid", fetch_rvalid_o, 1);
      chk("t2_pop_pc", fetched_pc_addr_o, 32'h0000_1000 + 32'(4 * i));
      if (i == 1) chk("t2_req_resumes", instr_req_o, 1);
      step();
    end
    repeat (6) step();

    // Kill with two requests in flight, 3-cycle memory.
    do_reset(1'b1);
    lat = 3;
    boot_at(32'h0000_2000);
    step();
    step();
    cu_pc_bra_i = 32'h0000_0100;
    cu_kill_f_i = 1'b1;
    peek();
    chk("t3_no_req_in_kill", instr_req_o, 0);
    step();
    cu_kill_f_i = 1'b0;
    wait_valid(found);
    chk("t3_found", found, 1);
    chk("t3_first_pc", fetched_pc_addr_o, 32'h0000_0100);
    chk("t3_first_instr", instr_o, mem_fn(32'h0000_0100));
    repeat (8) step();

    // Kill coinciding with a response, 2-cycle memory.
    do_reset(1'b1);
    lat = 2;
    boot_at(32'h0000_3000);
    step();
    step();
    cu_pc_bra_i = 32'h0000_0400;
    cu_kill_f_i = 1'b1;
    peek();
    chk("t4_rsp_with_kill", instr_rvalid_i, 1);
    step();
    cu_kill_f_i = 1'b0;
    peek();
    chk("t4_flushed", fetch_rvalid_o, 0);
    step();
    wait_valid(found);
    chk("t4_found", found, 1);
    chk("t4_first_pc", fetched_pc_addr_o, 32'h0000_0400);
    repeat (6) step();

    // Wrap-around.
    do_reset(1'b1);
    lat = 1;
    boot_at(32'hFFFF_FFFC);
    peek();
    chk("t5_addr_T1", instr_addr_o, 32'hFFFF_FFFC);
    step();
    peek();
    chk("t5_addr_T2", instr_addr_o, 32'h0000_0000);
    step();
    peek();
    chk("t5_pc_T3", fetched_pc_addr_o, 32'hFFFF_FFFC);
    chk("t5_next_T3", fetched_pc_next_addr_o, 32'h0000_0000);
    step();
    peek();
    chk("t5_pc_T4", fetched_pc_addr_o, 32'h0000_0000);
    repeat (4) step();

    // Reset mid-flight with two outstanding; late responses must be ignored.
    do_reset(1'b1);
    lat = 3;
    boot_at(32'h0000_5000);
    step();
    step();
    orphan_ok = 1'b1;
    arstn_i = 1'b0;
    peek();
    chk("t6_rst_req", instr_req_o, 0);
    chk("t6_rst_addr", instr_addr_o, 0);
    chk("t6_rst_valid", fetch_rvalid_o, 0);
    chk("t6_rst_pc_next", fetched_pc_next_addr_o, 4);
    step();
    arstn_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      peek();
      chk("t6_idle_req", instr_req_o, 0);
      chk("t6_idle_valid", fetch_rvalid_o, 0);
      step();
    end
    orphan_ok = 1'b0;
    lat = 1;
    boot_at(32'h0000_6000);
    peek();
    chk("t6_reboot_req", instr_req_o, 1);
    chk("t6_reboot_addr", instr_addr_o, 32'h0000_6000);
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
